// File: rtl/dma_uart_rw.sv
// Bidirectional UART DMA engine: writes send header+payload, reads send a header and collect the reply.
// Optional trailing XOR checksum byte on every frame when DMA_UART_CHECKSUM_EN is defined.

module uart_tx #(
  parameter int CLK_HZ   = 50000000,
  parameter int BIT_RATE = 4800
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_busy,
  output logic       uart_txd
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);

  logic [8:0]    r_shift;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_cyc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift      <= '1;
      r_bit        <= '0;
      r_cyc        <= '0;
      uart_tx_busy <= 1'b0;
      uart_txd     <= 1'b1;
    end else if (!uart_tx_busy) begin
      if (uart_tx_en) begin
        r_shift      <= {1'b1, uart_tx_data};
        r_bit        <= '0;
        r_cyc        <= '0;
        uart_tx_busy <= 1'b1;
        uart_txd     <= 1'b0;
      end
    end else if (r_cyc == CW'(CPB - 1)) begin
      r_cyc <= '0;
      if (r_bit == 4'd9) begin
        uart_tx_busy <= 1'b0;
        uart_txd     <= 1'b1;
      end else begin
        // Data bits go out LSB first; the stop bit is the 1 shifted in behind them.
        uart_txd <= r_shift[0];
        r_shift  <= {1'b1, r_shift[8:1]};
        r_bit    <= r_bit + 4'd1;
      end
    end else begin
      r_cyc <= r_cyc + 1'b1;
    end
  end
endmodule

module uart_rx #(
  parameter int CLK_HZ   = 50000000,
  parameter int BIT_RATE = 4800
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  output logic       uart_rx_valid,
  output logic       uart_rx_break,
  output logic [7:0] uart_rx_data
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;

  rx_state_t     r_state;
  logic          r_s1, r_s2;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_cyc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= RX_IDLE;
      r_s1          <= 1'b1;
      r_s2          <= 1'b1;
      r_bit         <= '0;
      r_cyc         <= '0;
      uart_rx_data  <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
    end else begin
      r_s1          <= uart_rxd;
      r_s2          <= r_s1;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      case (r_state)
        RX_IDLE: if (!r_s2) begin
          r_cyc   <= '0;
          r_state <= RX_START;
        end
        RX_START: if (r_cyc == CW'(CPB / 2 - 1)) begin
          // Re-check the start bit at mid-bit to reject glitches.
          r_cyc   <= '0;
          r_bit   <= '0;
          r_state <= r_s2 ? RX_IDLE : RX_DATA;
        end else r_cyc <= r_cyc + 1'b1;
        RX_DATA: if (r_cyc == CW'(CPB - 1)) begin
          r_cyc        <= '0;
          uart_rx_data <= {r_s2, uart_rx_data[7:1]};
          r_bit        <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= RX_STOP;
        end else r_cyc <= r_cyc + 1'b1;
        RX_STOP: if (r_cyc == CW'(CPB - 1)) begin
          r_cyc <= '0;
          if (r_s2) begin
            uart_rx_valid <= 1'b1;
            r_state       <= RX_IDLE;
          end else begin
            // Framing error; all-zero data with a low stop bit is a line break.
            uart_rx_break <= (uart_rx_data == 8'h00);
            r_state       <= RX_HOLD;
          end
        end else r_cyc <= r_cyc + 1'b1;
        RX_HOLD: if (r_s2) r_state <= RX_IDLE;
        default: r_state <= RX_IDLE;
      endcase
    end
  end
endmodule

module dma_uart_rw #(
  parameter int CLK_HZ         = 50000000,
  parameter int BIT_RATE       = 4800,
  parameter int ADDR_BITS      = 7,
  parameter int DATA_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [ADDR_BITS-1:0] dma_addr,
  input  logic [DATA_BITS-1:0] dma_dat_w,
  input  logic                 we,
  input  logic                 re,
  output logic [DATA_BITS-1:0] dma_dat_r,
  output logic                 rvalid,
  output logic                 err,
  output logic                 busy,
  input  logic                 uart_rxd,
  output logic                 uart_txd
);
  localparam int HDR_BYTES  = (ADDR_BITS + 8) / 8;
  localparam int DATA_BYTES = DATA_BITS / 8;
  localparam int HDR_W      = 8 * HDR_BYTES;
  localparam int FRAME_W    = HDR_W + DATA_BITS;
`ifdef DMA_UART_CHECKSUM_EN
  localparam bit CSUM_EN    = 1'b1;
`else
  localparam bit CSUM_EN    = 1'b0;
`endif
  localparam int CS_BYTES   = CSUM_EN ? 1 : 0;
  localparam int TX_WR      = HDR_BYTES + DATA_BYTES + CS_BYTES;
  localparam int TX_RD      = HDR_BYTES + CS_BYTES;
  localparam int RX_N       = DATA_BYTES + CS_BYTES;
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_TX_LOAD, S_TX_PULSE, S_TX_WAIT, S_RX_WAIT, S_DONE} state_t;

  state_t               r_state;
  logic                 r_is_wr;
  logic [FRAME_W-1:0]   r_frame;
  logic [3:0]           r_idx, r_ntx, r_rx_cnt;
  logic [7:0]           r_csum, r_tx_data;
  logic                 r_tx_en;
  logic [DATA_BITS-1:0] r_asm;
  logic [TMO_W-1:0]     r_tmo;

  logic                 w_tx_busy, w_rx_valid, w_rx_break;
  logic [7:0]           w_rx_data;
  logic [HDR_W-1:0]     w_hdr;
  logic [DATA_BITS-1:0] w_payload, w_asm_next;

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    w_hdr                  = '0;
    w_hdr[HDR_W-1]         = we;
    w_hdr[ADDR_BITS-1:0]   = dma_addr;
  end

  assign w_payload  = we ? dma_dat_w : '0;
  assign w_asm_next = DATA_BITS'({r_asm, w_rx_data});

  uart_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) u_tx (
    .clk(clk), .resetn(resetn), .uart_tx_en(r_tx_en), .uart_tx_data(r_tx_data),
    .uart_tx_busy(w_tx_busy), .uart_txd(uart_txd)
  );

  uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) u_rx (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_valid(w_rx_valid),
    .uart_rx_break(w_rx_break), .uart_rx_data(w_rx_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_is_wr   <= 1'b0;
      r_frame   <= '0;
      r_idx     <= '0;
      r_ntx     <= '0;
      r_rx_cnt  <= '0;
      r_csum    <= '0;
      r_tx_data <= '0;
      r_tx_en   <= 1'b0;
      r_asm     <= '0;
      r_tmo     <= '0;
      dma_dat_r <= '0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (we || re) begin
          // Write takes priority; a simultaneous read is dropped, not queued.
          r_is_wr <= we;
          r_frame <= {w_hdr, w_payload};
          r_ntx   <= we ? 4'(TX_WR) : 4'(TX_RD);
          r_idx   <= '0;
          r_csum  <= '0;
          busy    <= 1'b1;
          r_state <= S_TX_LOAD;
        end
        S_TX_LOAD: begin
          r_tx_en <= 1'b1;
          if (CSUM_EN && (r_idx == r_ntx - 4'd1)) begin
            r_tx_data <= r_csum;
          end else begin
            r_tx_data <= r_frame[FRAME_W-1 -: 8];
            r_csum    <= r_csum ^ r_frame[FRAME_W-1 -: 8];
            r_frame   <= r_frame << 8;
          end
          r_idx   <= r_idx + 4'd1;
          r_state <= S_TX_PULSE;
        end
        S_TX_PULSE: begin
          r_tx_en <= 1'b0;
          r_state <= S_TX_WAIT;
        end
        S_TX_WAIT: if (!w_tx_busy) begin
          if (r_idx != r_ntx) begin
            r_state <= S_TX_LOAD;
          end else if (r_is_wr) begin
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_rx_cnt <= '0;
            r_tmo    <= '0;
            r_csum   <= '0;
            r_asm    <= '0;
            r_state  <= S_RX_WAIT;
          end
        end
        S_RX_WAIT: begin
          if (w_rx_break || (r_tmo == TMO_LAST)) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (w_rx_valid) begin
            r_tmo    <= '0;
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (r_rx_cnt == 4'(RX_N - 1)) begin
              busy    <= 1'b0;
              r_state <= S_DONE;
              if (CSUM_EN) begin
                if (w_rx_data == r_csum) begin
                  dma_dat_r <= r_asm;
                  rvalid    <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end else begin
                dma_dat_r <= w_asm_next;
                rvalid    <= 1'b1;
              end
            end else begin
              r_asm  <= w_asm_next;
              r_csum <= r_csum ^ w_rx_data;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          rvalid  <= 1'b0;
          err     <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_uart_rw.sv
// Randomized self-checking bench for dma_uart_rw with a byte-level host model on both UART pins.
// Checksum scenarios are included when DMA_UART_CHECKSUM_EN is defined.

module tb_dma_uart_rw;
  localparam int BIT_RATE   = 4800;
  localparam int CLK_HZ     = 8 * BIT_RATE;
  localparam int CPB        = 8;
  localparam int TMO        = 400;
  localparam int HDR_BYTES  = 1;
  localparam int DATA_BYTES = 2;
`ifdef DMA_UART_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  dma_addr = '0;
  logic [15:0] dma_dat_w = '0;
  logic        we = 1'b0, re = 1'b0;
  logic [15:0] dma_dat_r;
  logic        rvalid, err, busy;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tx_done_cyc = 0;
  logic [7:0]  mon_b;
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rep_q[$];
  logic [15:0] last_rd = '0;

  dma_uart_rw #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .ADDR_BITS(7), .DATA_BITS(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .dma_addr(dma_addr), .dma_dat_w(dma_dat_w), .we(we), .re(re),
    .dma_dat_r(dma_dat_r), .rvalid(rvalid), .err(err), .busy(busy),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Host-side receiver: decodes 8N1 bytes on uart_txd, sampling mid-bit on falling clock edges.
  initial forever begin
    @(negedge clk);
    if (uart_txd === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = uart_txd;
      end
      repeat (CPB) @(negedge clk);
      if (uart_txd === 1'b1) begin
        tx_q.push_back(mon_b);
        tx_done_cyc = cyc + CPB / 2;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  // Expected request frame from the framing rules: header word, payload, optional XOR byte.
  task automatic model_tx(input bit dir, input int addr, input int data, input bit with_data);
    int hdr;
    int x;
    logic [7:0] b;
    exp_q.delete();
    x = 0;
    hdr = dir * (1 << (8 * HDR_BYTES - 1)) + addr;
    for (int i = HDR_BYTES - 1; i >= 0; i--) begin
      b = 8'((hdr >> (8 * i)) % 256);
      exp_q.push_back(b);
      x = x ^ int'(b);
    end
    if (with_data) begin
      for (int i = DATA_BYTES - 1; i >= 0; i--) begin
        b = 8'((data >> (8 * i)) % 256);
        exp_q.push_back(b);
        x = x ^ int'(b);
      end
    end
    if (CS) exp_q.push_back(8'(x));
  endtask

  // Host reply: data bytes MSB first, then the XOR byte (optionally corrupted) in checksum builds.
  task automatic model_reply(input int data, input bit corrupt);
    int x;
    logic [7:0] b;
    rep_q.delete();
    x = 0;
    for (int i = DATA_BYTES - 1; i >= 0; i--) begin
      b = 8'((data >> (8 * i)) % 256);
      rep_q.push_back(b);
      x = x ^ int'(b);
    end
    if (CS) rep_q.push_back(8'(corrupt ? (x ^ 255) : x));
  endtask

  function automatic bit tx_match();
    if (tx_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (tx_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string show(input bit use_tx);
    string s;
    s = "";
    if (use_tx) foreach (tx_q[i]) s = {s, $sformatf("%02h ", tx_q[i])};
    else        foreach (exp_q[i]) s = {s, $sformatf("%02h ", exp_q[i])};
    return s;
  endfunction

  task automatic issue(input bit w, input bit r, input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    we = w; re = r; dma_addr = a; dma_dat_w = d;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 3000 && tx_q.size() < n; i++) @(negedge clk);
  endtask

  // Waits for busy to fall; rv/er are the pulse levels in that cycle, stray flags early pulses.
  task automatic wait_done(output bit ok, output bit rv, output bit er, output bit stray,
                           output int ecyc);
    ok = 1'b0; rv = 1'b0; er = 1'b0; stray = 1'b0; ecyc = 0;
    for (int n = 0; n < 6000; n++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        rv = (rvalid === 1'b1);
        er = (err === 1'b1);
        ecyc = cyc;
        break;
      end
      if (rvalid === 1'b1 || err === 1'b1) stray = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rvalid !== 1'b0)    begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (dma_dat_r !== 16'h0) begin bad++; $display("FAIL reset_dat got=%h want=0000", dma_dat_r); end
    total++; if (uart_txd !== 1'b1)  begin bad++; $display("FAIL reset_txd got=%b want=1", uart_txd); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write(input string name, input logic [6:0] a, input logic [15:0] d);
    bit ok, rv, er, stray;
    int ec;
    model_tx(1'b1, a, d, 1'b1);
    tx_q.delete();
    issue(1'b1, 1'b0, a, d);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise got=%b want=1", name, busy); end
    wait_done(ok, rv, er, stray, ec);
    total++; if (!ok) begin bad++; $display("FAIL %s_done got=timeout want=busy_fall", name); end
    total++; if (rv || er || stray) begin
      bad++; $display("FAIL %s_pulses got=rv%0b er%0b stray%0b want=none", name, rv, er, stray);
    end
    total++; if (!tx_match()) begin
      bad++; $display("FAIL %s_frame got=%s want=%s", name, show(1'b1), show(1'b0));
    end
  endtask

  task automatic test_read(input string name, input logic [6:0] a, input logic [15:0] d,
                           input bit corrupt);
    bit ok, rv, er, stray;
    int ec;
    bit want_rv;
    logic [15:0] want_dat;
    model_tx(1'b0, a, 0, 1'b0);
    model_reply(int'(d), corrupt);
    want_rv  = !corrupt;
    want_dat = corrupt ? last_rd : d;
    tx_q.delete();
    issue(1'b0, 1'b1, a, 16'h0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise got=%b want=1", name, busy); end
    fork
      begin
        wait_tx(exp_q.size());
        repeat (CPB) @(negedge clk);
        foreach (rep_q[i]) send_byte(rep_q[i]);
      end
      wait_done(ok, rv, er, stray, ec);
    join
    total++; if (!ok) begin bad++; $display("FAIL %s_done got=timeout want=busy_fall", name); end
    total++; if (rv !== want_rv || er !== !want_rv || stray) begin
      bad++; $display("FAIL %s_pulse got=rv%0b er%0b stray%0b want=rv%0b er%0b", name, rv, er, stray,
                      want_rv, !want_rv);
    end
    total++; if (dma_dat_r !== want_dat) begin
      bad++; $display("FAIL %s_data got=%h want=%h", name, dma_dat_r, want_dat);
    end
    total++; if (!tx_match()) begin
      bad++; $display("FAIL %s_frame got=%s want=%s", name, show(1'b1), show(1'b0));
    end
    @(negedge clk);
    total++; if (rvalid !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL %s_one_cycle got=rv%0b er%0b want=0 0", name, rvalid, err);
    end
    if (want_rv) last_rd = d;
  endtask

  task automatic test_timeout();
    bit ok, rv, er, stray;
    int ec, dly;
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    model_tx(1'b0, a, 0, 1'b0);
    tx_q.delete();
    issue(1'b0, 1'b1, a, 16'h0);
    wait_done(ok, rv, er, stray, ec);
    dly = ec - tx_done_cyc;
    total++; if (!ok) begin bad++; $display("FAIL tmo_done got=timeout want=busy_fall"); end
    total++; if (!er || rv || stray) begin
      bad++; $display("FAIL tmo_pulse got=rv%0b er%0b stray%0b want=rv0 er1", rv, er, stray);
    end
    total++; if (dly < TMO - 4 || dly > TMO + 6) begin
      bad++; $display("FAIL tmo_delay got=%0d want=%0d(+-)", dly, TMO);
    end
    total++; if (dma_dat_r !== last_rd) begin
      bad++; $display("FAIL tmo_data_held got=%h want=%h", dma_dat_r, last_rd);
    end
    total++; if (!tx_match()) begin
      bad++; $display("FAIL tmo_frame got=%s want=%s", show(1'b1), show(1'b0));
    end
    test_write("after_tmo", 7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)));
  endtask

  task automatic test_we_re();
    bit ok, rv, er, stray;
    int ec;
    logic [6:0] a;
    logic [15:0] d;
    a = 7'($urandom_range(0, 127));
    d = 16'($urandom_range(0, 65535));
    model_tx(1'b1, a, d, 1'b1);
    tx_q.delete();
    issue(1'b1, 1'b1, a, d);
    repeat (40) @(negedge clk);
    re = 1'b1; dma_addr = ~a;
    @(negedge clk);
    re = 1'b0;
    repeat (60) @(negedge clk);
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    wait_done(ok, rv, er, stray, ec);
    repeat (200) @(negedge clk);
    total++; if (!ok || rv || er || stray) begin
      bad++; $display("FAIL we_re_pulses got=ok%0b rv%0b er%0b want=ok1 rv0 er0", ok, rv, er);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL we_re_idle got=%b want=0", busy); end
    total++; if (!tx_match()) begin
      bad++; $display("FAIL we_re_frame got=%s want=%s", show(1'b1), show(1'b0));
    end
  endtask

  task automatic test_reset_mid();
    tx_q.delete();
    issue(1'b1, 1'b0, 7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)));
    wait_tx(1);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL rst_mid_txd got=%b want=1", uart_txd); end
    total++; if (rvalid !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL rst_mid_pulse got=rv%0b er%0b want=0 0", rvalid, err);
    end
    @(negedge clk);
    resetn = 1'b1;
    last_rd = '0;
    repeat (100) @(negedge clk);
    tx_q.delete();
    test_read("rd_after_rst", 7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_write("wr_fixed", 7'h05, 16'hB03D);
    for (int i = 0; i < 3; i++)
      test_write("wr_rand", 7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)));
    test_read("rd_fixed", 7'h12, 16'hAFFE, 1'b0);
    for (int i = 0; i < 3; i++)
      test_read("rd_rand", 7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)), 1'b0);
    test_timeout();
    test_we_re();
    test_reset_mid();
`ifdef DMA_UART_CHECKSUM_EN
    test_read("rd_bad_cs", 7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)), 1'b1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
